// File: rtl/ads1118_spi_slave.sv
// ADS1118-style SPI mode-1 responder; SCLK/CS_n/MOSI oversampled in clk.
// Shifts the held conversion word out on MISO while the config word comes in.
//
// Ports:
//   clk_i, rst_i          system clock, sync active-high reset
//   sclk_i, cs_n_i, mosi_i  async SPI pins from the master
//   miso_o, miso_oe_o     DOUT/DRDY and its tristate enable
//   adc_data_i/adc_valid_i  local conversion word and capture strobe
//   data_ready_o          hold register has an unread word
//   cfg_o, cfg_update_o   accepted config word and its write pulse
//   frame_done_o          16th falling SCLK edge seen
//   frame_err_o           cs_n rose with 1..15 bits received

module ads1118_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] CFG_RESET   = 16'h058B
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [15:0] adc_data_i,
  input  logic        adc_valid_i,
  output logic        data_ready_o,
  output logic [15:0] cfg_o,
  output logic        cfg_update_o,
  output logic        frame_done_o,
  output logic        frame_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, cs_rise, cs_edge;
  logic sclk_rise, sclk_fall;

  logic [4:0]  cnt_q;
  logic [14:0] rx_q;
  logic [15:0] rx_nxt;
  logic [14:0] tx_q;
  logic        miso_bit_q;
  logic [15:0] hold_q;
  logic        ready_q;
  logic        take_q;
  logic [15:0] cfg_q;
  logic        upd_q, done_q, err_q;
  logic        nop_ok;

  logic snap, shift_tx, shift_rx;
  logic complete, abort;

  // Synchronisers carry no reset: a reset must not fabricate
  // pin edges, otherwise a held-low cs_n would re-arm mid-frame.
  always_ff @(posedge clk_i) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sclk_prev_q <= sclk_s;
    cs_prev_q   <= cs_s;
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign cs_edge = cs_fall | cs_rise;

  // A chip-select edge in the same cycle swallows the SCLK edge.
  assign sclk_rise = ~sclk_prev_q & sclk_s & ~cs_edge;
  assign sclk_fall = sclk_prev_q & ~sclk_s & ~cs_edge;

  assign rx_nxt = {rx_q, mosi_s};
  assign nop_ok = (rx_nxt[2:1] == 2'b01);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_fall && cnt_q == 5'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath-control logic
  always_comb begin
    miso_o    = 1'b0;
    miso_oe_o = 1'b0;
    snap      = 1'b0;
    shift_tx  = 1'b0;
    shift_rx  = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        miso_oe_o = 1'b0;
      end
      ST_ARMED: begin
        miso_oe_o = 1'b1;
        miso_o    = ~ready_q;
        snap      = sclk_rise;
      end
      ST_SHIFT: begin
        miso_oe_o = 1'b1;
        miso_o    = miso_bit_q;
        shift_tx  = sclk_rise;
        shift_rx  = sclk_fall;
        complete  = sclk_fall && (cnt_q == 5'd15);
        abort     = cs_rise && (cnt_q != 5'd0);
      end
      ST_DONE: begin
        miso_oe_o = 1'b1;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_bit_q <= 1'b0;
      hold_q     <= '0;
      ready_q    <= 1'b0;
      take_q     <= 1'b0;
      cfg_q      <= CFG_RESET;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= complete;
      err_q  <= abort;
      upd_q  <= complete & nop_ok;

      if (complete && nop_ok) begin
        cfg_q <= {rx_nxt[15:1], 1'b1};
      end

      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        rx_q  <= '0;
      end else if (shift_rx) begin
        rx_q <= rx_nxt[14:0];
        if (cnt_q != 5'd16) cnt_q <= cnt_q + 5'd1;
      end

      // tx_q keeps the bits still to send; zeros fill in
      // so rises past the 16th drive 0.
      if (snap) begin
        tx_q       <= hold_q[14:0];
        miso_bit_q <= hold_q[15];
      end else if (shift_tx) begin
        tx_q       <= {tx_q[13:0], 1'b0};
        miso_bit_q <= tx_q[14];
      end

      // take_q: the word snapshotted for this frame is still
      // the one in hold. A newer word stays pending.
      if (snap) begin
        take_q <= ~adc_valid_i;
      end else if (adc_valid_i) begin
        take_q <= 1'b0;
      end

      if (adc_valid_i) begin
        hold_q  <= adc_data_i;
        ready_q <= 1'b1;
      end else if (complete && take_q) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign data_ready_o = ready_q;
  assign cfg_o        = cfg_q;
  assign cfg_update_o = upd_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule
